// File: rtl/reset_sequencer.sv
// reset_sequencer: always-on reset sequencer.
// Releases N_DOM domain resets in a fixed order after power-on. It then
// serves per-domain soft resets over a 4-phase req/ack handshake. It also
// holds the configuration registers that drive the reset generator pins.
// Ports:
//   CLK_I, RST_I        clock and synchronous active-high reset
//   GAP_I               release-to-release spacing minus one
//   GLB_RST_REQ_I       restart of the full release sequence
//   SW_RST_REQ_I/ACK_O  per-domain soft reset handshake
//   DOM_RST_N_O         active-low domain resets
//   SEQ_DONE_O          all domains released
//   CFG_*_I / *_O       generator configuration (TIMER, EN_N_CR, EN_N_CS)
module reset_sequencer #(
    parameter int unsigned N_DOM     = 4,
    parameter int unsigned HOLD_CYC  = 16,
    parameter logic [7:0]  TIMER_DEF = 8'h10
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    input  logic [7:0]       GAP_I,
    input  logic             GLB_RST_REQ_I,
    input  logic [N_DOM-1:0] SW_RST_REQ_I,
    output logic [N_DOM-1:0] SW_RST_ACK_O,
    output logic [N_DOM-1:0] DOM_RST_N_O,
    output logic             SEQ_DONE_O,
    input  logic             CFG_WE_I,
    input  logic [7:0]       CFG_TIMER_I,
    input  logic             CFG_EN_N_CR_I,
    input  logic             CFG_EN_N_CS_I,
    output logic [7:0]       TIMER_O,
    output logic             EN_N_CR_O,
    output logic             EN_N_CS_O
);

    localparam int unsigned IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;
    localparam int unsigned CNT_W = 8;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DOM - 1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_GAP,
        ST_RUN,
        ST_SOFT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_DOM-1:0]   dom_rst_n_q, dom_rst_n_d;
    logic [N_DOM-1:0]   ack_q, ack_d;
    logic               done_q, done_d;
    logic [7:0]         timer_q, timer_d;
    logic               en_n_cr_q, en_n_cr_d;
    logic               en_n_cs_q, en_n_cs_d;

    logic [N_DOM-1:0]   elig;
    logic               sel_vld;
    logic [IDX_W-1:0]   sel_idx;

    // Lowest-index pending soft request that has not been acknowledged yet
    always_comb begin
        elig    = SW_RST_REQ_I & ~ack_q;
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < N_DOM; i++) begin
            if (elig[i] && !sel_vld) begin
                sel_vld = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    // Next-state and output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        dom_rst_n_d = dom_rst_n_q;
        done_d      = done_q;
        timer_d     = timer_q;
        en_n_cr_d   = en_n_cr_q;
        en_n_cs_d   = en_n_cs_q;
        // An ACK is kept only while its request is still high
        ack_d       = ack_q & SW_RST_REQ_I;

        if (CFG_WE_I) begin
            timer_d   = CFG_TIMER_I;
            en_n_cr_d = CFG_EN_N_CR_I;
            en_n_cs_d = CFG_EN_N_CS_I;
        end

        unique case (state_q)
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    dom_rst_n_d[0] = 1'b1;
                    if (N_DOM == 1) begin
                        done_d  = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        idx_d   = IDX_W'(1);
                        cnt_d   = GAP_I;
                        state_d = ST_GAP;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                if (cnt_q == '0) begin
                    dom_rst_n_d[idx_q] = 1'b1;
                    if (idx_q == IDX_LAST) begin
                        done_d  = 1'b1;
                        state_d = ST_RUN;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                        cnt_d = GAP_I;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            ST_RUN: begin
                if (sel_vld) begin
                    dom_rst_n_d[sel_idx] = 1'b0;
                    idx_d   = sel_idx;
                    cnt_d   = '0;
                    state_d = ST_SOFT;
                end
            end

            ST_SOFT: begin
                if (cnt_q == HOLD_LAST) begin
                    dom_rst_n_d[idx_q] = 1'b1;
                    ack_d[idx_q]       = 1'b1;
                    state_d            = ST_RUN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = ST_HOLD;
            end
        endcase

        // Global restart overrides sequencing and soft resets, not config
        if (GLB_RST_REQ_I) begin
            dom_rst_n_d = '0;
            ack_d       = '0;
            done_d      = 1'b0;
            cnt_d       = '0;
            idx_d       = '0;
            state_d     = ST_HOLD;
        end
    end

    // State and output registers
    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q     <= ST_HOLD;
            cnt_q       <= '0;
            idx_q       <= '0;
            dom_rst_n_q <= '0;
            ack_q       <= '0;
            done_q      <= 1'b0;
            timer_q     <= TIMER_DEF;
            en_n_cr_q   <= 1'b0;
            en_n_cs_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            dom_rst_n_q <= dom_rst_n_d;
            ack_q       <= ack_d;
            done_q      <= done_d;
            timer_q     <= timer_d;
            en_n_cr_q   <= en_n_cr_d;
            en_n_cs_q   <= en_n_cs_d;
        end
    end

    assign DOM_RST_N_O  = dom_rst_n_q;
    assign SW_RST_ACK_O = ack_q;
    assign SEQ_DONE_O   = done_q;
    assign TIMER_O      = timer_q;
    assign EN_N_CR_O    = en_n_cr_q;
    assign EN_N_CS_O    = en_n_cs_q;

endmodule
